// File: rtl/tone_sequencer.sv
// Programmable note-table sequencer producing a full-scale/zero square-wave duty value
// for the PWM serializer, with start/stop/loop control and a completion pulse.
module tone_sequencer #(
    parameter int unsigned NOTE_COUNT = 32,
    parameter int unsigned HALF_WIDTH = 18,
    parameter int unsigned DUR_WIDTH  = 24,
    parameter logic [9:0]  DUTY_HIGH  = 10'd1023
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          loop,
    input  logic                          wr_en,
    input  logic [$clog2(NOTE_COUNT)-1:0] wr_addr,
    input  logic [HALF_WIDTH-1:0]         wr_half,
    input  logic [DUR_WIDTH-1:0]          wr_dur,
    output logic [9:0]                    duty_cycle,
    output logic                          busy,
    output logic [$clog2(NOTE_COUNT)-1:0] note_index,
    output logic                          done
);

    localparam int unsigned IDX_WIDTH = $clog2(NOTE_COUNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_DONE
    } state_t;

    state_t                 state_q,    state_d;
    logic [HALF_WIDTH-1:0]  half_tbl_q [NOTE_COUNT];
    logic [HALF_WIDTH-1:0]  half_tbl_d [NOTE_COUNT];
    logic [DUR_WIDTH-1:0]   dur_tbl_q  [NOTE_COUNT];
    logic [DUR_WIDTH-1:0]   dur_tbl_d  [NOTE_COUNT];
    logic [IDX_WIDTH-1:0]   index_q,    index_d;
    logic [HALF_WIDTH-1:0]  half_q,     half_d;
    logic [HALF_WIDTH-1:0]  half_cnt_q, half_cnt_d;
    logic [DUR_WIDTH-1:0]   dur_cnt_q,  dur_cnt_d;
    logic                   phase_q,    phase_d;
    logic [9:0]             duty_q,     duty_d;
    logic                   busy_q,     busy_d;
    logic                   done_q,     done_d;

    logic [HALF_WIDTH-1:0]  entry_half;
    logic [DUR_WIDTH-1:0]   entry_dur;
    logic                   last_entry;

    assign entry_half = half_tbl_q[index_q];
    assign entry_dur  = dur_tbl_q[index_q];
    assign last_entry = (index_q == IDX_WIDTH'(NOTE_COUNT - 1));

    always_comb begin
        half_tbl_d = half_tbl_q;
        dur_tbl_d  = dur_tbl_q;
        if (wr_en && !busy_q) begin
            half_tbl_d[wr_addr] = wr_half;
            dur_tbl_d[wr_addr]  = wr_dur;
        end
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        half_d     = half_q;
        half_cnt_d = half_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        phase_d    = phase_q;

        if (stop) begin
            state_d = S_IDLE;
            phase_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        index_d = '0;
                        state_d = S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (entry_dur == '0) begin
                        // Wrap only from a nonzero index so an empty table still finishes.
                        if (loop && (index_q != '0)) begin
                            index_d = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        dur_cnt_d  = entry_dur - DUR_WIDTH'(1);
                        half_cnt_d = '0;
                        half_d     = entry_half;
                        phase_d    = (entry_half != '0);
                        state_d    = S_PLAY;
                    end
                end

                S_PLAY: begin
                    if (dur_cnt_q == '0) begin
                        if (last_entry) begin
                            if (loop) begin
                                index_d = '0;
                                state_d = S_LOAD;
                            end else begin
                                state_d = S_DONE;
                            end
                        end else begin
                            index_d = index_q + IDX_WIDTH'(1);
                            state_d = S_LOAD;
                        end
                    end else begin
                        dur_cnt_d = dur_cnt_q - DUR_WIDTH'(1);
                    end

                    if (half_q != '0) begin
                        if (half_cnt_q == half_q - HALF_WIDTH'(1)) begin
                            phase_d    = ~phase_q;
                            half_cnt_d = '0;
                        end else begin
                            half_cnt_d = half_cnt_q + HALF_WIDTH'(1);
                        end
                    end
                end

                S_DONE: begin
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are registered copies of the decode of the next state.
    always_comb begin
        duty_d = (state_d == S_PLAY && phase_d) ? DUTY_HIGH : '0;
        busy_d = (state_d == S_LOAD) || (state_d == S_PLAY);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            half_q     <= '0;
            half_cnt_q <= '0;
            dur_cnt_q  <= '0;
            phase_q    <= 1'b0;
            duty_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int unsigned i = 0; i < NOTE_COUNT; i++) begin
                half_tbl_q[i] <= '0;
                dur_tbl_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            half_q     <= half_d;
            half_cnt_q <= half_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
            phase_q    <= phase_d;
            duty_q     <= duty_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            half_tbl_q <= half_tbl_d;
            dur_tbl_q  <= dur_tbl_d;
        end
    end

    assign duty_cycle = duty_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign note_index = index_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: expected per-cycle outputs are queued from note timing
// rules and compared, one cycle per entry, on the falling clock edge.
module tb_tone_sequencer;

    localparam int NC = 32;
    localparam int HW = 18;
    localparam int DW = 24;
    localparam logic [9:0] HIGH = 10'd1023;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic          loop;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [HW-1:0] wr_half;
    logic [DW-1:0] wr_dur;
    logic [9:0]    duty_cycle;
    logic          busy;
    logic [4:0]    note_index;
    logic          done;

    typedef struct packed {
        logic [9:0] duty;
        logic       busy;
        logic       done;
        logic [4:0] idx;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fails  = 0;
    int    cyc      = 0;
    string tag      = "";

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    tone_sequencer #(
        .NOTE_COUNT(NC),
        .HALF_WIDTH(HW),
        .DUR_WIDTH(DW),
        .DUTY_HIGH(HIGH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stop(stop),
        .loop(loop),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_half(wr_half),
        .wr_dur(wr_dur),
        .duty_cycle(duty_cycle),
        .busy(busy),
        .note_index(note_index),
        .done(done)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic void push(logic [9:0] d, logic b, logic dn, int idx);
        exp_t e;
        e.duty = d;
        e.busy = b;
        e.done = dn;
        e.idx  = 5'(idx);
        exp_q.push_back(e);
    endfunction

    // LOAD cycle followed by the first n PLAY cycles of a note with half-period h.
    function automatic void push_part(int idx, int h, int n);
        push(10'd0, 1'b1, 1'b0, idx);
        for (int k = 0; k < n; k++)
            push((h != 0 && ((k / h) % 2 == 0)) ? HIGH : 10'd0, 1'b1, 1'b0, idx);
    endfunction

    function automatic void push_note(int idx, int h, int d);
        push_part(idx, h, d);
    endfunction

    function automatic void push_idle(int idx, int n);
        for (int k = 0; k < n; k++) push(10'd0, 1'b0, 1'b0, idx);
    endfunction

    task automatic check_pop();
        exp_t e;
        exp_t o;
        e = exp_q.pop_front();
        o = {duty_cycle, busy, done, note_index};
        n_checks++;
        assert (o === e) else begin
            n_fails++;
            $error("FAIL %s cyc %0d duty/busy/done/idx: got %0d/%b/%b/%0d expected %0d/%b/%b/%0d",
                   tag, cyc, o.duty, o.busy, o.done, o.idx, e.duty, e.busy, e.done, e.idx);
        end
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            check_pop();
            tick();
        end
    endtask

    task automatic write_entry(int a, int h, int d);
        wr_en   = 1'b1;
        wr_addr = 5'(a);
        wr_half = HW'(h);
        wr_dur  = DW'(d);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_half = '0; wr_dur = '0;
        tick();
        do_reset();

        tag = "reset_idle";
        push_idle(0, 20);
        drain();

        tag = "single_note";
        write_entry(0, 3, 10);
        write_entry(1, 0, 0);
        pulse_start();
        push_note(0, 3, 10);
        push(10'd0, 1'b1, 1'b0, 1);
        push(10'd0, 1'b0, 1'b1, 1);
        push_idle(1, 3);
        drain();

        tag = "rest_index";
        write_entry(0, 0, 5);
        write_entry(1, 1, 4);
        write_entry(2, 0, 0);
        pulse_start();
        push_note(0, 0, 5);
        push_note(1, 1, 4);
        push(10'd0, 1'b1, 1'b0, 2);
        push(10'd0, 1'b0, 1'b1, 2);
        push_idle(2, 2);
        drain();

        tag = "loop_wrap";
        write_entry(0, 2, 3);
        write_entry(1, 1, 2);
        write_entry(2, 0, 0);
        loop = 1'b1;
        pulse_start();
        for (int r = 0; r < 2; r++) begin
            push_note(0, 2, 3);
            push_note(1, 1, 2);
            push(10'd0, 1'b1, 1'b0, 2);
        end
        push_note(0, 2, 3);
        push_note(1, 1, 2);
        drain();
        loop = 1'b0;
        tag = "loop_exit";
        push(10'd0, 1'b1, 1'b0, 2);
        push(10'd0, 1'b0, 1'b1, 2);
        push_idle(2, 2);
        drain();

        tag = "full_table_wrap";
        for (int i = 0; i < NC; i++) write_entry(i, 1 + i % 3, 1 + i % 2);
        loop = 1'b1;
        pulse_start();
        for (int i = 0; i < NC; i++) push_note(i, 1 + i % 3, 1 + i % 2);
        push_note(0, 1, 1);
        drain();
        loop = 1'b0;
        tag = "full_table_end";
        for (int i = 1; i < NC; i++) push_note(i, 1 + i % 3, 1 + i % 2);
        push(10'd0, 1'b0, 1'b1, NC - 1);
        push_idle(NC - 1, 2);
        drain();

        tag = "stop_mid_note";
        write_entry(0, 4, 20);
        write_entry(1, 0, 0);
        pulse_start();
        push_part(0, 4, 3);
        drain();
        stop  = 1'b1;
        start = 1'b1;
        push(HIGH, 1'b1, 1'b0, 0);
        check_pop();
        tick();
        stop  = 1'b0;
        start = 1'b0;
        tag = "after_stop";
        push_idle(0, 5);
        drain();
        tag = "restart";
        pulse_start();
        push_note(0, 4, 20);
        push(10'd0, 1'b1, 1'b0, 1);
        push(10'd0, 1'b0, 1'b1, 1);
        push_idle(1, 2);
        drain();

        tag = "write_lockout";
        write_entry(0, 2, 6);
        pulse_start();
        push_note(0, 2, 6);
        push(10'd0, 1'b1, 1'b0, 1);
        push(10'd0, 1'b0, 1'b1, 1);
        push_idle(1, 2);
        wr_en = 1'b1; wr_addr = 5'd0; wr_half = HW'(5); wr_dur = DW'(9);
        check_pop();
        tick();
        wr_addr = 5'd1; wr_half = HW'(3); wr_dur = DW'(3);
        check_pop();
        tick();
        wr_en = 1'b0;
        drain();
        tag = "lockout_replay";
        pulse_start();
        push_note(0, 2, 6);
        push(10'd0, 1'b1, 1'b0, 1);
        push(10'd0, 1'b0, 1'b1, 1);
        push_idle(1, 2);
        drain();

        tag = "empty_table";
        do_reset();
        push_idle(0, 3);
        drain();
        loop = 1'b1;
        pulse_start();
        push(10'd0, 1'b1, 1'b0, 0);
        push(10'd0, 1'b0, 1'b1, 0);
        push_idle(0, 3);
        drain();
        loop = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

- Upstream of the PWM serializer in the audio path.
- Plays a programmable table of notes. Each entry holds a half-period and a duration, both counted in system-clock cycles.
- Output is a 10-bit square-wave duty cycle (full-scale or zero) that feeds the serializer's `duty_cycle` input.
- Replaces free-running note stepping with start/stop/loop control and a completion pulse, so game logic can trigger sound effects.

## Interface

Parameters:
- `NOTE_COUNT`, 32: number of table entries. Must be a power of two.
- `HALF_WIDTH`, 18: width of the half-period field.
- `DUR_WIDTH`, 24: width of the duration field.
- `DUTY_HIGH`, 10'd1023: duty value driven during the high phase.

Ports:
- `clk`, in, 1: system clock. One clock domain only.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin playback at entry 0. Sampled only in IDLE.
- `stop`, in, 1: abort playback. Has priority over every other event.
- `loop`, in, 1: when 1 at the end of the sequence, wrap to entry 0 instead of finishing. Sampled at the end of the sequence.
- `wr_en`, in, 1: table write strobe. Ignored while `busy`=1.
- `wr_addr`, in, log2(NOTE_COUNT): entry index for the write.
- `wr_half`, in, HALF_WIDTH: half-period in cycles. 0 means rest (silence).
- `wr_dur`, in, DUR_WIDTH: note length in cycles. 0 marks the end of the sequence.
- `duty_cycle`, out, 10: DUTY_HIGH during the high phase, otherwise 0.
- `busy`, out, 1: 1 in the LOAD and PLAY states.
- `note_index`, out, log2(NOTE_COUNT): index of the current entry.
- `done`, out, 1: one-cycle pulse on natural completion.

## Operation

- Table: NOTE_COUNT registers of {half, dur}.
  - A write takes effect on the clock edge where `wr_en`=1 and `busy`=0.
  - `reset` clears all entries to 0.
- States: IDLE, LOAD, PLAY, DONE.
- IDLE:
  - `start`=1 → set index to 0 and go to LOAD.
- LOAD (exactly 1 cycle), reads entry[index]:
  - If dur==0 (terminator):
    - If `loop`=1 and index≠0 → set index to 0 and stay in LOAD.
    - Otherwise → go to DONE. An empty table therefore never loops forever.
  - Otherwise:
    - Set the duration counter to dur−1 and the half counter to 0.
    - Set phase to (half≠0).
    - Go to PLAY.
- PLAY (each cycle):
  - If the duration counter ==0:
    - If index==NOTE_COUNT−1: same end handling as a terminator. `loop`=1 → index 0, LOAD. Otherwise → DONE.
    - Otherwise: index+1, go to LOAD.
  - Otherwise: decrement the duration counter.
  - If half≠0 and the half counter == half−1: toggle phase and clear the half counter. Otherwise increment the half counter.
  - If half==0: phase stays 0.
- DONE (1 cycle): `done`=1, then go to IDLE.
- `stop`=1 in any state → IDLE on the next edge.
  - No `done` pulse.
  - `duty_cycle` is 0 from that edge onward.
  - A `start` in the same cycle as `stop` is ignored.
- A `start` while `busy`=1 is ignored.
- Widths: counters are sized to their field widths, with no overflow. half=1 toggles the phase every cycle.

## Timing

- Reset values:
  - State IDLE.
  - `duty_cycle`=0, `busy`=0, `note_index`=0, `done`=0.
  - Phase 0, all counters 0, table cleared.
- Outputs are decoded from registered state only, with no combinational path from inputs:
  - `duty_cycle` = DUTY_HIGH iff (state==PLAY and phase==1).
  - `busy` = (state==LOAD or state==PLAY).
  - `done` = (state==DONE).
  - `note_index` is the index register.
- `start` sampled at edge t → LOAD is visible in cycle t+1 and PLAY in cycle t+2.
- The first high duty cycle appears at t+2.
- A note with half=h≠0 and dur=d occupies exactly d PLAY cycles:
  - Output is high for h cycles, then low for h cycles, repeating.
  - The final partial half-period is truncated.
- Each note is preceded by 1 LOAD cycle with duty 0.
- Playing N notes of durations d1..dN with no terminator takes N + Σdi cycles from the first LOAD to DONE.
- `done` is high in the cycle after the last PLAY or terminator LOAD.
- Loop wrap inserts 1 extra LOAD cycle when it starts from a terminator at index≠0.

## Test plan

- **Reset defaults:** reset for 2 cycles, then hold `start`=0 → all outputs 0 and `busy`=0 for 20 cycles.
- **Single note:**
  - Stimulus: write entry0={half=3, dur=10}, entry1 dur=0, pulse `start`.
  - Required: duty pattern over PLAY is 1023×3, 0×3, 1023×3, 0×1.
  - Required: `done` pulses exactly once, 13 cycles after LOAD begins (LOAD0 + 10 PLAY + LOAD1 terminator + DONE).
- **Rest and index:**
  - Stimulus: entry0={half=0, dur=5}, entry1={half=1, dur=4}, entry2 dur=0.
  - Required: duty 0 for 5 cycles, then alternating 1023/0 for 4 cycles.
  - Required: `note_index` steps 0→1→2.
- **Loop and wrap:**
  - Stimulus: `loop`=1, table of 2 notes then a terminator.
  - Required: after the terminator LOAD, index returns to 0 and the pattern repeats with no `done`.
  - Stimulus: clear `loop` → `done` at the next terminator.
  - Stimulus: all 32 entries nonzero with `loop`=1 → index wraps 31→0.
- **Stop mid-note:**
  - Stimulus: assert `stop` during PLAY with duty=1023.
  - Required: next cycle duty=0, `busy`=0, no `done`.
  - Required: a `start` in the same cycle as `stop` is ignored, and a later `start` restarts at index 0.
- **Write lockout and empty table:**
  - Stimulus: `wr_en` during PLAY → entry unchanged when read back by replay.
  - Stimulus: all-zero table with `loop`=1 → `start` yields LOAD then DONE, with `done` at t+2.
